// File: rtl/nco_tone_generator_pkg.sv
// Shared definitions for the NCO tone generator: FSM encoding and a tuning-word helper.
package nco_tone_generator_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Rounded tuning word for f_out / f_clk = num / den with an acc_width-bit accumulator.
  function automatic logic [63:0] tw_from_ratio(input logic [31:0] num, input logic [31:0] den,
                                                input int unsigned acc_width);
    logic [63:0] scaled;
    scaled = {32'd0, num} << acc_width;
    return (scaled + {33'd0, den[31:1]}) / {32'd0, den};
  endfunction

endpackage

// File: rtl/nco_phase_accumulator.sv
// Phase accumulator with carry-out boundary flag and registered square-wave output.
module nco_phase_accumulator
  import nco_tone_generator_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 24
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [ACC_WIDTH-1:0] tw,
  output logic                 boundary,
  output logic                 tone_out
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;

  // Extra bit captures the wrap; a carry is where the output falls, i.e. a cycle boundary.
  assign sum      = {1'b0, acc} + {1'b0, tw};
  assign boundary = enable & sum[ACC_WIDTH];

  // Advance phase while enabled; clear forces a clean zero phase with the output low.
  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      acc      <= '0;
      tone_out <= 1'b0;
    end else if (enable) begin
      acc      <= sum[ACC_WIDTH-1:0];
      tone_out <= sum[ACC_WIDTH-1];
    end
  end

endmodule

// File: rtl/nco_tone_generator.sv
// Programmable square-wave source: burst or continuous tone with boundary-aligned retune/abort.
module nco_tone_generator
  import nco_tone_generator_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ACC_WIDTH-1:0]   tuning_word,
  input  logic [COUNT_WIDTH-1:0] burst_length,
  input  logic                   abort,
  output logic                   tone_out,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] cycles_emitted
);

  state_e                 state;
  logic [ACC_WIDTH-1:0]   tw_active;
  logic [ACC_WIDTH-1:0]   pend_tw;
  logic                   pend_valid;
  logic [COUNT_WIDTH-1:0] burst_len;
  logic                   abort_seen;

  logic                   boundary;
  logic                   cmd_accept;
  logic                   run_end;
  logic                   acc_clear;
  logic [COUNT_WIDTH-1:0] count_next;

  // Only one retune may be outstanding; idle always takes a command.
  assign cmd_ready  = (state == StIdle) || !pend_valid;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign busy       = (state == StRun);
  assign count_next = cycles_emitted + COUNT_WIDTH'(1);

  // A pending zero word behaves like an abort at the boundary it would have taken effect.
  assign run_end = ((burst_len != '0) && (count_next == burst_len)) || abort_seen ||
                   (pend_valid && (pend_tw == '0));

  assign acc_clear = ((state == StIdle) && cmd_accept) ||
                     ((state == StRun) && boundary && run_end);

  nco_phase_accumulator #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .CLK      (CLK),
    .reset    (reset),
    .clear    (acc_clear),
    .enable   (busy),
    .tw       (tw_active),
    .boundary (boundary),
    .tone_out (tone_out)
  );

  // Run control: command intake, pending retune, sticky abort and end-of-run handling.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= StIdle;
      tw_active      <= '0;
      pend_tw        <= '0;
      pend_valid     <= 1'b0;
      burst_len      <= '0;
      abort_seen     <= 1'b0;
      done           <= 1'b0;
      cycles_emitted <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (cmd_accept) begin
            cycles_emitted <= '0;
            if (tuning_word == '0) begin
              done <= 1'b1;
            end else begin
              tw_active <= tuning_word;
              burst_len <= burst_length;
              state     <= StRun;
            end
          end
        end
        StRun: begin
          if (abort) abort_seen <= 1'b1;
          if (cmd_accept) begin
            pend_valid <= 1'b1;
            pend_tw    <= tuning_word;
          end
          if (boundary) begin
            cycles_emitted <= count_next;
            if (run_end) begin
              // Ending the run discards any retune and clears the sticky abort.
              state      <= StIdle;
              done       <= 1'b1;
              abort_seen <= 1'b0;
              pend_valid <= 1'b0;
            end else if (pend_valid) begin
              // New word applies to the add after the wrap, so phase continues from the residue.
              tw_active  <= pend_tw;
              pend_valid <= 1'b0;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_tone_generator.sv
// Scoreboarded bench for nco_tone_generator: expected run-end counts are queued at command time
// and popped by a monitor whenever done pulses; waveform/handshake checks run inline.
module tb_nco_tone_generator;

  localparam int unsigned AW = 24;
  localparam int unsigned CW = 16;

  logic          CLK = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] tuning_word;
  logic [CW-1:0] burst_length;
  logic          abort;
  logic          tone_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycles_emitted;

  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] exp_q[$];
  logic [3:0]    pat   = 4'b1100;

  always #5 CLK = ~CLK;

  nco_tone_generator #(
    .ACC_WIDTH   (AW),
    .COUNT_WIDTH (CW)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .tuning_word    (tuning_word),
    .burst_length   (burst_length),
    .abort          (abort),
    .tone_out       (tone_out),
    .busy           (busy),
    .done           (done),
    .cycles_emitted (cycles_emitted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Issue a command at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [AW-1:0] tw, input logic [CW-1:0] bl);
    cmd_valid    = 1'b1;
    tuning_word  = tw;
    burst_length = bl;
    @(negedge CLK);
    cmd_valid    = 1'b0;
  endtask

  // Monitor: every done pulse must match the next queued run-end count.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      logic [CW-1:0] e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: cycles_emitted=%0d, no run end expected (t=%0t)",
                 cycles_emitted, $time);
      end else begin
        e = exp_q.pop_front();
        check("done_cycles", cycles_emitted, e);
        check("done_busy", busy, 0);
      end
    end
  end

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    tuning_word  = '0;
    burst_length = '0;
    abort        = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_tone", tone_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cycles", cycles_emitted, 0);
    check("rst_ready", cmd_ready, 1);
    reset = 1'b0;
    @(negedge CLK);

    // Burst of 3 at period 4.
    exp_q.push_back(16'd3);
    send(24'h400000, 16'd3);
    for (int i = 0; i < 12; i++) begin
      check("burst_busy", busy, 1);
      check("burst_tone", tone_out, pat[i%4]);
      @(negedge CLK);
    end
    check("burst_end_busy", busy, 0);
    check("burst_end_tone", tone_out, 0);
    check("burst_end_cycles", cycles_emitted, 3);
    check("burst_end_ready", cmd_ready, 1);
    @(negedge CLK);

    // Continuous period 2, abort ends at the following boundary.
    send(24'h800000, 16'd0);
    repeat (100) @(negedge CLK);
    check("cont_cycles", cycles_emitted, 50);
    check("cont_tone", tone_out, 0);
    check("cont_busy", busy, 1);
    exp_q.push_back(16'd51);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("abort_wait_tone", tone_out, 1);
    check("abort_wait_busy", busy, 1);
    check("abort_wait_cycles", cycles_emitted, 50);
    @(negedge CLK);
    check("abort_end_busy", busy, 0);
    check("abort_end_tone", tone_out, 0);
    check("abort_end_cycles", cycles_emitted, 51);
    check("abort_end_ready", cmd_ready, 1);
    @(negedge CLK);

    // Retune mid-cycle: current 4-CLK period finishes, then period 2; burst field ignored.
    send(24'h400000, 16'd0);
    repeat (5) @(negedge CLK);
    check("rt_ready_before", cmd_ready, 1);
    check("rt_tone5", tone_out, 0);
    cmd_valid    = 1'b1;
    tuning_word  = 24'h800000;
    burst_length = 16'd3;
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("rt_ready6", cmd_ready, 0);
    check("rt_tone6", tone_out, 1);
    @(negedge CLK);
    check("rt_ready7", cmd_ready, 0);
    check("rt_tone7", tone_out, 1);
    check("rt_cycles7", cycles_emitted, 1);
    @(negedge CLK);
    check("rt_ready8", cmd_ready, 1);
    check("rt_tone8", tone_out, 0);
    check("rt_cycles8", cycles_emitted, 2);
    @(negedge CLK);
    check("rt_tone9", tone_out, 1);
    @(negedge CLK);
    check("rt_tone10", tone_out, 0);
    check("rt_cycles10", cycles_emitted, 3);
    check("rt_busy10", busy, 1);
    @(negedge CLK);
    check("rt_tone11", tone_out, 1);
    @(negedge CLK);
    check("rt_tone12", tone_out, 0);
    check("rt_cycles12", cycles_emitted, 4);

    // Zero word while running ends the run at the next boundary.
    exp_q.push_back(16'd5);
    send(24'h000000, 16'd0);
    check("zrun_busy13", busy, 1);
    check("zrun_ready13", cmd_ready, 0);
    @(negedge CLK);
    check("zrun_busy14", busy, 0);
    check("zrun_tone14", tone_out, 0);
    check("zrun_cycles14", cycles_emitted, 5);
    @(negedge CLK);

    // Zero word in idle: no run, immediate done with zero count.
    exp_q.push_back(16'd0);
    send(24'h000000, 16'd5);
    check("zidle_busy", busy, 0);
    check("zidle_cycles", cycles_emitted, 0);
    check("zidle_ready", cmd_ready, 1);
    @(negedge CLK);
    check("zidle_busy_later", busy, 0);

    // Reset mid-run: output stops immediately, no done.
    send(24'h400000, 16'd1000);
    repeat (10) @(negedge CLK);
    check("rstrun_cycles_pre", cycles_emitted, 2);
    check("rstrun_tone_pre", tone_out, 1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    check("rstrun_tone", tone_out, 0);
    check("rstrun_busy", busy, 0);
    check("rstrun_done", done, 0);
    check("rstrun_cycles", cycles_emitted, 0);
    check("rstrun_ready", cmd_ready, 1);
    repeat (3) @(negedge CLK);
    check("rstrun_idle", busy, 0);

    // Frequency: f_clk/20 over 2^16 CLKs gives floor(65536*838861/2^24) = 3276 boundaries.
    exp_q.push_back(16'd3277);
    send(24'h0CCCCD, 16'd0);
    repeat (65536) @(negedge CLK);
    check("freq_cycles", cycles_emitted, 3276);
    check("freq_busy", busy, 1);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    repeat (2) @(negedge CLK);
    check("freq_abort_wait", busy, 1);
    @(negedge CLK);
    check("freq_abort_end", busy, 0);
    check("freq_end_cycles", cycles_emitted, 3277);

    repeat (3) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
